// File: rtl/rsc_fetch_seq.sv
// Instruction fetch sequencer: drives PC onto the bus, latches MAR, requests memory,
// latches IR, bumps PC, then hands off to execute; HALT and FAULT are sticky until reset.
module rsc_fetch_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] busIn,
    output logic [1:0]  pcEnables,
    output logic [15:0] marOut,
    output logic        memReq,
    input  logic        memAck,
    input  logic [15:0] memData,
    output logic [15:0] irOut,
    output logic        execStart,
    input  logic        execDone,
    output logic        halted,
    output logic        fault,
    output logic [2:0]  state,
    output logic [15:0] fetchCount
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PC_OUT  = 3'd1,
        S_MEM_REQ = 3'd2,
        S_PC_INC  = 3'd3,
        S_EXEC    = 3'd4,
        S_HALT    = 3'd5,
        S_FAULT   = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  wait_q, wait_d;
    logic        first_q, first_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mar_q   <= 16'h0000;
            ir_q    <= 16'h0000;
            cnt_q   <= 16'h0000;
            wait_q  <= 4'h0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_PC_OUT;
            S_PC_OUT: begin
                mar_d   = busIn;
                wait_d  = 4'h0;
                state_d = S_MEM_REQ;
            end
            S_MEM_REQ: begin
                // An ack on the last allowed cycle still completes the fetch.
                if (memAck) begin
                    ir_d    = memData;
                    cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'h0001;
                    state_d = S_PC_INC;
                end else if (wait_q == 4'hF) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 4'h1;
                end
            end
            S_PC_INC: state_d = (ir_q[15:12] == 4'hF) ? S_HALT : S_EXEC;
            S_EXEC:   if (execDone) state_d = run ? S_PC_OUT : S_IDLE;
            S_HALT:   state_d = S_HALT;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase
        // Flag the first EXEC cycle so execStart stays a registered decode.
        first_d = (state_q == S_PC_INC) && (state_d == S_EXEC);
    end

    assign state      = state_q;
    assign pcEnables  = (state_q == S_PC_OUT) ? 2'b01 :
                        (state_q == S_PC_INC) ? 2'b10 : 2'b00;
    assign memReq     = (state_q == S_MEM_REQ);
    assign execStart  = (state_q == S_EXEC) && first_q;
    assign halted     = (state_q == S_HALT);
    assign fault      = (state_q == S_FAULT);
    assign marOut     = mar_q;
    assign irOut      = ir_q;
    assign fetchCount = cnt_q;

endmodule

// File: tb/tb_rsc_fetch_seq.sv
// Directed bench for rsc_fetch_seq: fetch, halt, timeout, run drop, async reset,
// plus per-cycle output invariants.
module tb_rsc_fetch_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [15:0] busIn = 16'h0000;
    logic [1:0]  pcEnables;
    logic [15:0] marOut;
    logic        memReq;
    logic        memAck = 1'b0;
    logic [15:0] memData = 16'h0000;
    logic [15:0] irOut;
    logic        execStart;
    logic        execDone = 1'b0;
    logic        halted;
    logic        fault;
    logic [2:0]  state;
    logic [15:0] fetchCount;

    int n_chk  = 0;
    int n_pass = 0;

    rsc_fetch_seq dut (
        .clk(clk), .rst(rst), .run(run), .busIn(busIn), .pcEnables(pcEnables),
        .marOut(marOut), .memReq(memReq), .memAck(memAck), .memData(memData),
        .irOut(irOut), .execStart(execStart), .execDone(execDone), .halted(halted),
        .fault(fault), .state(state), .fetchCount(fetchCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle invariants, sampled on the falling edge.
    logic pc_driven = 1'b0;
    logic xs_prev   = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            pc_driven = 1'b0;
            xs_prev   = 1'b0;
        end else begin
            chk("inv_pc11", {31'd0, pcEnables == 2'b11}, 32'd0);
            if (pcEnables == 2'b01) pc_driven = 1'b1;
            if (pcEnables == 2'b10) begin
                chk("inv_inc_after_out", {31'd0, pc_driven}, 32'd1);
                pc_driven = 1'b0;
            end
            chk("inv_xs_consec", {31'd0, xs_prev & execStart}, 32'd0);
            xs_prev = execStart;
        end
    end

    initial begin
        // Reset values while held in reset
        #2;
        chk("rst_state", state, 0);
        chk("rst_pcen", pcEnables, 0);
        chk("rst_memreq", memReq, 0);
        chk("rst_flags", {execStart, halted, fault}, 0);
        chk("rst_regs", {marOut, irOut}, 0);
        chk("rst_cnt", fetchCount, 0);
        tick();
        chk("rst_hold_state", state, 0);
        rst = 1'b0;
        tick();
        chk("idle_no_run", state, 0);

        // Basic fetch
        run = 1'b1; busIn = 16'h0003;
        tick(); chk("bf_pcout", state, 1); chk("bf_pcen01", pcEnables, 2'b01);
        chk("bf_memreq0", memReq, 0);
        tick(); chk("bf_mem1", state, 2); chk("bf_mar", marOut, 16'h0003);
        chk("bf_memreq1", memReq, 1); chk("bf_pcen00", pcEnables, 0);
        tick(); chk("bf_mem2", state, 2);
        tick(); chk("bf_mem3", state, 2);
        memAck = 1'b1; memData = 16'h1234;
        tick(); memAck = 1'b0;
        chk("bf_pcinc", state, 3); chk("bf_pcen10", pcEnables, 2'b10);
        chk("bf_ir", irOut, 16'h1234); chk("bf_cnt", fetchCount, 1);
        chk("bf_xs_pcinc", execStart, 0);
        tick(); chk("bf_exec", state, 4); chk("bf_xs1", execStart, 1);
        tick(); chk("bf_xs_c2", {state, execStart}, {3'd4, 1'b0});
        tick(); chk("bf_xs_c3", {state, execStart}, {3'd4, 1'b0});
        tick(); chk("bf_xs_c4", {state, execStart}, {3'd4, 1'b0});
        execDone = 1'b1; busIn = 16'h0010;
        tick(); execDone = 1'b0;
        chk("bf_again_pcout", state, 1);

        // Halt on opcode F
        tick(); chk("h_mem", state, 2); chk("h_mar", marOut, 16'h0010);
        memAck = 1'b1; memData = 16'hF000;
        tick(); memAck = 1'b0;
        chk("h_pcinc", state, 3); chk("h_cnt", fetchCount, 2);
        tick(); chk("h_halt", state, 5); chk("h_halted", halted, 1);
        chk("h_ctl", {pcEnables, memReq, execStart, fault}, 0);
        run = 1'b0; tick(); chk("h_stay0", state, 5);
        run = 1'b1; tick(); chk("h_stay1", state, 5);
        execDone = 1'b1; tick(); execDone = 1'b0;
        chk("h_stay2", state, 5); chk("h_xs", execStart, 0);

        // Async reset in MEM_REQ
        rst = 1'b1; #2; rst = 1'b0;
        chk("r_from_halt", {state, halted}, 0);
        busIn = 16'h0055;
        tick(); chk("ar_pcout", state, 1);
        tick(); chk("ar_mem", state, 2); chk("ar_mar", marOut, 16'h0055);
        #3 rst = 1'b1;
        #1;
        chk("ar_memreq", memReq, 0); chk("ar_state", state, 0);
        chk("ar_pcen", pcEnables, 0); chk("ar_regs", {marOut, irOut}, 0);
        chk("ar_cnt", fetchCount, 0); chk("ar_flags", {execStart, halted, fault}, 0);
        tick(); chk("ar_hold", state, 0);
        rst = 1'b0;
        tick(); chk("ar_first_edge", state, 1);

        // Timeout: 16 MEM_REQ cycles without ack
        tick(); chk("to_mem1", state, 2);
        for (int i = 2; i <= 16; i++) tick();
        chk("to_mem16", state, 2);
        tick(); chk("to_fault", state, 6); chk("to_faultbit", fault, 1);
        chk("to_memreq", memReq, 0); chk("to_ctl", {pcEnables, execStart, halted}, 0);
        memAck = 1'b1; tick(); memAck = 1'b0;
        chk("to_stay", state, 6); chk("to_cnt", fetchCount, 0);

        // Ack on exactly the 16th cycle
        rst = 1'b1; #2; rst = 1'b0;
        tick(); chk("a16_pcout", state, 1);
        tick();
        for (int i = 2; i <= 16; i++) tick();
        chk("a16_mem16", state, 2);
        memAck = 1'b1; memData = 16'h0042;
        tick(); memAck = 1'b0;
        chk("a16_pcinc", state, 3); chk("a16_fault", fault, 0);
        chk("a16_ir", irOut, 16'h0042); chk("a16_cnt", fetchCount, 1);
        tick(); chk("a16_exec", state, 4);

        // Run drop mid-fetch
        execDone = 1'b1;
        tick(); execDone = 1'b0;
        chk("rd_pcout", state, 1);
        tick(); chk("rd_mem", state, 2);
        run = 1'b0;
        tick(); chk("rd_mem2", state, 2);
        memAck = 1'b1; memData = 16'h0100;
        tick(); memAck = 1'b0;
        chk("rd_pcinc", state, 3); chk("rd_cnt", fetchCount, 2);
        tick(); chk("rd_exec", state, 4);
        tick(); chk("rd_exec_hold1", state, 4);
        tick(); chk("rd_exec_hold2", state, 4);
        execDone = 1'b1;
        tick(); execDone = 1'b0;
        chk("rd_idle", state, 0);
        memAck = 1'b1; memData = 16'hDEAD; execDone = 1'b1;
        tick(); memAck = 1'b0; execDone = 1'b0;
        chk("sp_state", state, 0); chk("sp_ir", irOut, 16'h0100);
        chk("sp_cnt", fetchCount, 2);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
